// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes a raw key level, samples it on a slow strobe and
// only accepts a new level after FILT consecutive disagreeing samples.
module key_debounce #(
   parameter int unsigned DIV  = 16,
   parameter int unsigned FILT = 4,
   parameter int unsigned INV  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_en,
   output logic key_clean,
   output logic key_chg
);

   localparam int unsigned    CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
   localparam logic [7:0]     MCNT_LAST = 8'(FILT - 1);
   localparam logic           INV_BIT   = (INV != 0);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    mcnt_q, mcnt_d;
   logic          clean_q, clean_d;
   logic          en_q;
   logic          chg_q, chg_d;
   logic          stb;

   assign stb = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d   = stb ? '0 : cnt_q + CW'(1);
      mcnt_d  = mcnt_q;
      clean_d = clean_q;
      chg_d   = 1'b0;
      if (stb) begin
         if (sync2_q != clean_q) begin
            // The FILT-th disagreeing sample commits the new level instead of counting on.
            if (mcnt_q == MCNT_LAST) begin
               clean_d = sync2_q;
               mcnt_d  = '0;
               chg_d   = 1'b1;
            end else begin
               mcnt_d = mcnt_q + 8'd1;
            end
         end else begin
            mcnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         mcnt_q  <= '0;
         clean_q <= 1'b0;
         en_q    <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= key_raw ^ INV_BIT;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         mcnt_q  <= mcnt_d;
         clean_q <= clean_d;
         en_q    <= stb;
         chg_q   <= chg_d;
      end
   end

   assign key_en    = en_q;
   assign key_clean = clean_q;
   assign key_chg   = chg_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: three instances with different parameters; expected key_chg
// events are queued when the key is driven and matched when the pulse appears.
module tb_key_debounce;

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic raw_a, raw_b, raw_c;
   logic en_a, clean_a, chg_a;
   logic en_b, clean_b, chg_b;
   logic en_c, clean_c, chg_c;

   int   cyc;
   int   total = 0;
   int   bad   = 0;
   ev_t  q_a[$], q_b[$], q_c[$];
   ev_t  ev_m;

   always #5 clk = ~clk;

   key_debounce #(.DIV(4), .FILT(3), .INV(0)) u_a (
      .clk(clk), .rst_n(rst_n), .key_raw(raw_a),
      .key_en(en_a), .key_clean(clean_a), .key_chg(chg_a));
   key_debounce #(.DIV(4), .FILT(3), .INV(1)) u_b (
      .clk(clk), .rst_n(rst_n), .key_raw(raw_b),
      .key_en(en_b), .key_clean(clean_b), .key_chg(chg_b));
   key_debounce #(.DIV(1), .FILT(1), .INV(0)) u_c (
      .clk(clk), .rst_n(rst_n), .key_raw(raw_c),
      .key_en(en_c), .key_clean(clean_c), .key_chg(chg_c));

   // Rising edges since reset release; strobe-driven updates land on multiples of DIV.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Key driven to a new level just after edge m: ks follows at edge m+2, the first usable
   // strobe is the first multiple of DIV at or after m+3, and FILT-1 further strobes commit it.
   function automatic int exp_cyc(int m, int div, int filt);
      int f;
      f = ((m + 3 + div - 1) / div) * div;
      return f + (filt - 1) * div;
   endfunction

   function automatic ev_t mk_ev(int c, logic v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      return e;
   endfunction

   // Scoreboard: each key_chg pulse must match the oldest queued event.
   always @(negedge clk) begin
      if (rst_n) begin
         if (chg_a) begin
            total++;
            if (q_a.size() == 0) begin
               bad++; $display("FAIL chg_a_unexpected: pulse at cyc %0d, none expected", cyc);
            end else begin
               ev_m = q_a.pop_front();
               if (ev_m.cyc !== cyc || ev_m.val !== clean_a || en_a !== 1'b1) begin
                  bad++;
                  $display("FAIL chg_a_event: got cyc=%0d clean=%0b en=%0b, need cyc=%0d clean=%0b en=1",
                           cyc, clean_a, en_a, ev_m.cyc, ev_m.val);
               end
            end
         end
         if (chg_b) begin
            total++;
            if (q_b.size() == 0) begin
               bad++; $display("FAIL chg_b_unexpected: pulse at cyc %0d, none expected", cyc);
            end else begin
               ev_m = q_b.pop_front();
               if (ev_m.cyc !== cyc || ev_m.val !== clean_b || en_b !== 1'b1) begin
                  bad++;
                  $display("FAIL chg_b_event: got cyc=%0d clean=%0b en=%0b, need cyc=%0d clean=%0b en=1",
                           cyc, clean_b, en_b, ev_m.cyc, ev_m.val);
               end
            end
         end
         if (chg_c) begin
            total++;
            if (q_c.size() == 0) begin
               bad++; $display("FAIL chg_c_unexpected: pulse at cyc %0d, none expected", cyc);
            end else begin
               ev_m = q_c.pop_front();
               if (ev_m.cyc !== cyc || ev_m.val !== clean_c || en_c !== 1'b1) begin
                  bad++;
                  $display("FAIL chg_c_event: got cyc=%0d clean=%0b en=%0b, need cyc=%0d clean=%0b en=1",
                           cyc, clean_c, en_c, ev_m.cyc, ev_m.val);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      raw_a = 1'b0; raw_b = 1'b1; raw_c = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({en_a, clean_a, chg_a} !== 3'b000) begin
         bad++; $display("FAIL reset_a: got en/clean/chg=%b, need 000", {en_a, clean_a, chg_a});
      end
      total++;
      if ({en_b, clean_b, chg_b} !== 3'b000) begin
         bad++; $display("FAIL reset_b: got en/clean/chg=%b, need 000", {en_b, clean_b, chg_b});
      end
      total++;
      if ({en_c, clean_c, chg_c} !== 3'b000) begin
         bad++; $display("FAIL reset_c: got en/clean/chg=%b, need 000", {en_c, clean_c, chg_c});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_cadence();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         total++;
         if (en_a !== (cyc % 4 == 0 && cyc != 0) || en_b !== en_a) begin
            bad++;
            $display("FAIL cadence_en: cyc=%0d got en_a=%0b en_b=%0b, need %0b",
                     cyc, en_a, en_b, (cyc % 4 == 0 && cyc != 0));
         end
         total++;
         if (clean_a !== 1'b0) begin
            bad++; $display("FAIL cadence_clean: cyc=%0d got %0b, need 0", cyc, clean_a);
         end
      end
   endtask

   task automatic test_clean_press();
      int m;
      int rise;
      for (int ph = 0; ph < 4; ph++) begin
         do @(negedge clk); while (cyc % 4 != ph);
         m = cyc;
         raw_a = 1'b1;
         q_a.push_back(mk_ev(exp_cyc(m, 4, 3), 1'b1));
         rise = -1;
         for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (rise < 0 && clean_a === 1'b1) rise = cyc;
         end
         total++;
         if (rise < 0 || rise - m < 11 || rise - m > 18) begin
            bad++;
            $display("FAIL press_latency: phase=%0d got %0d cycles, need 11..18",
                     ph, (rise < 0) ? -1 : rise - m);
         end
         m = cyc;
         raw_a = 1'b0;
         q_a.push_back(mk_ev(exp_cyc(m, 4, 3), 1'b0));
         repeat (24) @(negedge clk);
         total++;
         if (clean_a !== 1'b0) begin
            bad++; $display("FAIL release_level: phase=%0d got %0b, need 0", ph, clean_a);
         end
      end
      total++;
      if (q_a.size() != 0) begin
         bad++; $display("FAIL press_pending: got %0d events outstanding, need 0", q_a.size());
      end
   endtask

   task automatic test_bounce();
      do @(negedge clk); while (cyc % 4 != 0);
      raw_a = 1'b1; repeat (8) @(negedge clk);
      raw_a = 1'b0; repeat (4) @(negedge clk);
      raw_a = 1'b1; repeat (8) @(negedge clk);
      raw_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (clean_a !== 1'b0) begin
            bad++; $display("FAIL bounce_clean: cyc=%0d got %0b, need 0", cyc, clean_a);
         end
      end
      total++;
      if (q_a.size() != 0) begin
         bad++; $display("FAIL bounce_pending: got %0d events outstanding, need 0", q_a.size());
      end
   endtask

   task automatic test_polarity();
      int k;
      int pulses;
      pulses = 0;
      do @(negedge clk); while (cyc % 4 != 0);
      k = cyc;
      raw_b = 1'b0;
      q_b.push_back(mk_ev(exp_cyc(k, 4, 3), 1'b1));
      repeat (12) begin
         @(negedge clk);
         if (chg_b === 1'b1) pulses++;
      end
      total++;
      if (clean_b !== 1'b1) begin
         bad++; $display("FAIL polarity_press: got clean=%0b, need 1", clean_b);
      end
      raw_b = 1'b1;
      q_b.push_back(mk_ev(exp_cyc(cyc, 4, 3), 1'b0));
      repeat (20) begin
         @(negedge clk);
         if (chg_b === 1'b1) pulses++;
      end
      total++;
      if (clean_b !== 1'b0 || pulses != 2) begin
         bad++; $display("FAIL polarity_release: got clean=%0b pulses=%0d, need clean=0 pulses=2",
                         clean_b, pulses);
      end
      total++;
      if (q_b.size() != 0) begin
         bad++; $display("FAIL polarity_pending: got %0d events outstanding, need 0", q_b.size());
      end
   endtask

   task automatic test_div1();
      int gaps[6] = '{5, 3, 1, 2, 4, 6};
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         raw_c = ~raw_c;
         q_c.push_back(mk_ev(exp_cyc(cyc, 1, 1), raw_c));
         for (int i = 0; i < gaps[t]; i++) begin
            @(negedge clk);
            total++;
            if (en_c !== 1'b1) begin
               bad++; $display("FAIL div1_en: cyc=%0d got %0b, need 1", cyc, en_c);
            end
         end
      end
      repeat (6) @(negedge clk);
      total++;
      if (q_c.size() != 0 || clean_c !== raw_c) begin
         bad++; $display("FAIL div1_final: got pending=%0d clean=%0b, need pending=0 clean=%0b",
                         q_c.size(), clean_c, raw_c);
      end
   endtask

   task automatic test_reset_mid();
      do @(negedge clk); while (cyc % 4 != 0);
      raw_a = 1'b1;
      repeat (8) @(negedge clk);
      total++;
      if (en_a !== 1'b1 || clean_a !== 1'b0) begin
         bad++; $display("FAIL midrst_pre: got en=%0b clean=%0b, need en=1 clean=0", en_a, clean_a);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({en_a, clean_a, chg_a} !== 3'b000) begin
         bad++; $display("FAIL midrst_async: got en/clean/chg=%b, need 000", {en_a, clean_a, chg_a});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      q_a.push_back(mk_ev(exp_cyc(0, 4, 3), 1'b1));
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         total++;
         if (clean_a !== (cyc >= 12)) begin
            bad++; $display("FAIL midrst_requal: cyc=%0d got %0b, need %0b", cyc, clean_a, (cyc >= 12));
         end
      end
      total++;
      if (q_a.size() != 0) begin
         bad++; $display("FAIL midrst_pending: got %0d events outstanding, need 0", q_a.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cadence();
      test_clean_press();
      test_bounce();
      test_polarity();
      test_div1();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DIV, default 16, meaning the sample-strobe period in clk cycles (legal range 1..65535).
REQ-002 The block SHALL have parameter FILT, default 4, meaning the number of consecutive disagreeing samples required to change state (legal range 1..255).
REQ-003 The block SHALL have parameter INV, default 1, meaning that 1 inverts key_raw so an active-low button reads as pressed=1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock of the block.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port key_raw, input, 1 bit: the bouncing button level, asynchronous to clk.
REQ-007 The block SHALL have port key_en, output, 1 bit: a one-cycle sample-enable pulse for the downstream FSM's en.
REQ-008 The block SHALL have port key_clean, output, 1 bit: the debounced level for the downstream FSM's a input; 1 means pressed.
REQ-009 The block SHALL have port key_chg, output, 1 bit: a one-cycle pulse that asserts when key_clean has just changed.

Function
REQ-010 The block SHALL pass key_raw XOR INV through a 2-flop synchronizer; its output is ks, and both flops reset to 0.
REQ-011 The block SHALL use a strobe counter cnt of width clog2(DIV) (minimum 1 bit) that increments every cycle and wraps from DIV-1 to 0.
REQ-012 The internal strobe stb SHALL be 1 exactly in cycles where cnt==DIV-1, so it fires once every DIV cycles; with DIV=1, stb SHALL be 1 every cycle.
REQ-013 Filter: on each clock edge with stb=1 where ks!=key_clean, the block SHALL increment mcnt.
REQ-014 When that increment would make mcnt reach FILT, the block SHALL instead load key_clean<=ks and clear mcnt to 0.
REQ-015 On each clock edge with stb=1 where ks==key_clean, the block SHALL clear mcnt to 0, so a single agreeing sample restarts the count.
REQ-016 On clock edges with stb=0, mcnt and key_clean SHALL hold.
REQ-017 key_en SHALL be stb registered, asserting the cycle after a filter update, so key_clean is already stable whenever key_en=1.
REQ-018 key_chg SHALL be registered and SHALL be 1 for exactly one cycle, coincident with key_en, when the preceding stb edge changed key_clean; otherwise it SHALL be 0.
REQ-019 Bounce rejection: a ks excursion lasting fewer than FILT strobes SHALL NOT change key_clean.
REQ-020 Latency: a clean step on key_raw SHALL update key_clean within 2 + FILT*DIV + DIV clk cycles, and no sooner than 2 + (FILT-1)*DIV + 1.
REQ-021 Every output SHALL be driven directly from a flop; there SHALL be no combinational path from key_raw to any output.
REQ-022 cnt SHALL run continuously and independently of key activity, and mcnt SHALL never exceed FILT-1.

Reset
REQ-023 While rst_n=0, all of the following SHALL be 0: sync flops, cnt, mcnt, key_clean, key_en and key_chg.
REQ-024 Reset assertion SHALL take effect immediately, without waiting for a clk edge, including mid-count.
REQ-025 After rst_n deasserts, the first stb SHALL occur DIV-1 cycles later (cnt restarts from 0), and the first key_en one cycle after that.
REQ-026 A press held through reset SHALL be re-qualified from mcnt=0, so key_clean rises no earlier than FILT strobes after release of reset.

Verification
REQ-027 Scenario, strobe cadence: DIV=4, FILT=3, INV=0, key_raw=0 -> key_en pulses at cycles 4, 8, 12, ... after reset release, with key_clean=0 and key_chg=0 throughout.
REQ-028 Scenario, clean press: DIV=4, FILT=3, INV=0, key_raw steps 0->1 and holds -> key_clean=1 and key_chg=1 on the key_en following the 3rd strobe that samples ks=1, and key_chg=0 on all other cycles.
REQ-029 Scenario, bounce rejection: key_raw high for 2 strobes, low for 1, high for 2, then low -> key_clean stays 0 and key_chg never asserts.
REQ-030 Scenario, release and polarity: INV=1 with key_raw driven low for 3 strobes -> key_clean=1; then key_raw high for 3 strobes -> key_clean=0, giving two key_chg pulses total.
REQ-031 Scenario, DIV=1 and FILT=1: key_raw toggles -> key_en is constantly 1 after reset, and key_clean follows key_raw 3 cycles later.
REQ-032 Scenario, reset mid-operation: rst_n pulsed low while mcnt=2 of 3 -> all outputs go 0 immediately, and after release a full 3 strobes are required before key_clean rises.
